// File: rtl/ret_addr_stack.sv
// Return-address stack for the branch-prediction frontend.
// Calls push their return IP and returns pop it. The stack is circular:
// a push when the stack is full overwrites the oldest entry. Each jump
// carries a snapshot (ptr, cnt, top entry). On a mispredict, that
// snapshot restores the stack to its state at that jump.
module ret_addr_stack #(
  parameter int DEPTH    = 16,
  parameter int IP_WIDTH = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        decEn,
  input  logic                        stall,
  input  logic                        pushCallStack,
  input  logic                        popCallStack,
  input  logic [IP_WIDTH-1:0]         retIP,
  input  logic                        flush,
  input  logic [$clog2(DEPTH)-1:0]    flushPtr,
  input  logic [$clog2(DEPTH):0]      flushCnt,
  input  logic [IP_WIDTH-1:0]         flushTop,
  output logic [IP_WIDTH-1:0]         predIP,
  output logic                        predValid,
  output logic [$clog2(DEPTH)-1:0]    ckPtr,
  output logic [$clog2(DEPTH):0]      ckCnt,
  output logic [IP_WIDTH-1:0]         ckTop,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [IP_WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0]    ptr;
  logic [CNT_W-1:0]    cnt;

  logic                upd;
  logic                isFull;
  logic                isEmpty;
  logic [PTR_W-1:0]    ptrInc;
  logic [PTR_W-1:0]    ptrDec;
  logic [CNT_W-1:0]    flushCntClamped;

  logic [PTR_W-1:0]    nextPtr;
  logic [CNT_W-1:0]    nextCnt;
  logic                nextOverflow;
  logic                nextUnderflow;
  logic                wrEn;
  logic [PTR_W-1:0]    wrIdx;
  logic [IP_WIDTH-1:0] wrData;

  // A flush cycle never counts as a push/pop slot, even if decode fires.
  assign upd     = decEn & ~stall & ~flush;
  assign isFull  = (cnt == FULL_CNT);
  assign isEmpty = (cnt == '0);
  // DEPTH is a power of two, so plain binary wrap gives modulo-DEPTH.
  assign ptrInc  = ptr + PTR_W'(1);
  assign ptrDec  = ptr - PTR_W'(1);
  assign flushCntClamped = (flushCnt > FULL_CNT) ? FULL_CNT : flushCnt;

  // Next pointer, occupancy, array write and exception flags.
  // Flush outranks push/pop.
  always_comb begin
    nextPtr       = ptr;
    nextCnt       = cnt;
    nextOverflow  = 1'b0;
    nextUnderflow = 1'b0;
    wrEn          = 1'b0;
    wrIdx         = ptr;
    wrData        = retIP;

    if (flush) begin
      nextPtr = flushPtr;
      nextCnt = flushCntClamped;
      wrEn    = 1'b1;
      wrIdx   = flushPtr;
      wrData  = flushTop;
    end else if (upd) begin
      if (pushCallStack && popCallStack) begin
        // Return followed by a call in the same slot: replace the top entry.
        wrEn  = 1'b1;
        wrIdx = ptr;
      end else if (pushCallStack) begin
        nextPtr      = ptrInc;
        wrEn         = 1'b1;
        wrIdx        = ptrInc;
        nextOverflow = isFull;
        if (!isFull) begin
          nextCnt = cnt + CNT_W'(1);
        end
      end else if (popCallStack) begin
        if (isEmpty) begin
          nextUnderflow = 1'b1;
        end else begin
          nextPtr = ptrDec;
          nextCnt = cnt - CNT_W'(1);
        end
      end
    end
  end

  // Pointer, occupancy and one-cycle exception pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      ptr       <= nextPtr;
      cnt       <= nextCnt;
      overflow  <= nextOverflow;
      underflow <= nextUnderflow;
    end
  end

  // Entry array. It is cleared on reset so predIP is never X.
  // A pop does not clear an entry, so a later flush can restore it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (wrEn) begin
      entries[wrIdx] <= wrData;
    end
  end

  // Prediction and snapshot outputs are read from registered state only.
  always_comb begin
    predIP    = entries[ptr];
    predValid = ~isEmpty;
    ckPtr     = ptr;
    ckCnt     = cnt;
    ckTop     = entries[ptr];
  end

endmodule

// File: doc/ret_addr_stack.md
RET_ADDR_STACK -- requirements
Module: ret_addr_stack

Interface
REQ-001 Parameter: DEPTH, 16, number of return-address entries; power of two.
REQ-002 Parameter: IP_WIDTH, 48, width of an instruction address.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 decEn  in  1  decoded jump-slot valid this cycle.
REQ-006 stall  in  1  frontend stall; blocks push/pop when high.
REQ-007 pushCallStack  in  1  call decoded; push retIP.
REQ-008 popCallStack  in  1  return decoded; pop top entry.
REQ-009 retIP  in  IP_WIDTH  return address of the call (call IP + length).
REQ-010 flush  in  1  mispredict recovery; restore snapshot.
REQ-011 flushPtr  in  log2(DEPTH)  snapshot top pointer.
REQ-012 flushCnt  in  log2(DEPTH)+1  snapshot occupancy.
REQ-013 flushTop  in  IP_WIDTH  snapshot top-entry value.
REQ-014 predIP  out  IP_WIDTH  predicted return target = entry at top pointer.
REQ-015 predValid  out  1  occupancy nonzero.
REQ-016 ckPtr / ckCnt / ckTop  out  log2(DEPTH) / log2(DEPTH)+1 / IP_WIDTH  current snapshot, attached by the frontend to each jump.
REQ-017 overflow  out  1  one-cycle pulse: push at full.
REQ-018 underflow  out  1  one-cycle pulse: pop at empty.

Function
REQ-019 State: DEPTH x IP_WIDTH entry array, top pointer ptr, occupancy cnt (0..DEPTH).
REQ-020 Update enable: upd = decEn & ~stall & ~flush; with upd low, no push/pop takes effect.
REQ-021 Push only (upd, push, ~pop): ptr <= ptr+1 mod DEPTH; entry[ptr+1] <= retIP; cnt <= min(cnt+1, DEPTH).
REQ-022 Push at cnt==DEPTH: the oldest entry is overwritten by wrap-around; cnt stays DEPTH; overflow pulses for 1 cycle.
REQ-023 Pop only (upd, pop, ~push), cnt>0: ptr <= ptr-1 mod DEPTH; cnt <= cnt-1; the entry is not cleared.
REQ-024 Pop at cnt==0: ptr and cnt unchanged; underflow pulses for 1 cycle; predValid stays 0.
REQ-025 Push and pop in the same cycle (upd): entry[ptr] <= retIP; ptr and cnt unchanged (top replaced); no overflow/underflow.
REQ-026 Flush has priority over all push/pop: ptr <= flushPtr; cnt <= flushCnt; entry[flushPtr] <= flushTop; overflow/underflow forced 0 that cycle.
REQ-027 flushCnt > DEPTH is clamped to DEPTH.
REQ-028 predIP = entry[ptr] read combinationally from registered state; reflects an update in the cycle after the edge that performs it (1-cycle latency).
REQ-029 predValid = (cnt != 0); predIP is don't-care when predValid=0 but is driven from the array, never X after reset.
REQ-030 ckPtr = ptr, ckCnt = cnt, ckTop = entry[ptr], all taken from pre-update registered state of the current cycle.
REQ-031 overflow and underflow are registered; each asserts only in the cycle after the causing edge.
REQ-032 Pointer arithmetic wraps modulo DEPTH with no bubble; cnt never exceeds DEPTH and never goes below 0.

Reset
REQ-033 While rst=0: ptr=0, cnt=0, all entries=0, overflow=0, underflow=0; hence predIP=0, predValid=0, ckPtr=0, ckCnt=0, ckTop=0.
REQ-034 Reset asserted mid-operation clears state immediately, without waiting for clk; the first update after release takes effect on the first rising edge with rst=1.

Verification
REQ-035 Reset, push retIP=0x1000 then 0x2000 -> predIP=0x2000, cnt=2; pop -> predIP=0x1000, cnt=1; pop -> predValid=0.
REQ-036 17 pushes 0x100..0x110 with DEPTH=16 -> overflow pulses on the 17th only; cnt=16; then 16 pops return 0x110 down to 0x101; a 17th pop pulses underflow.
REQ-037 Push 0xA0, then push+pop together with retIP=0xB0 -> predIP=0xB0, cnt=1, ptr unchanged.
REQ-038 Snapshot ckPtr/ckCnt/ckTop after push 0x500; then pop, then push 0x600; flush with the snapshot -> predIP=0x500 and cnt restored; a push/pop in the flush cycle is ignored.
REQ-039 stall=1 with push=1 for 3 cycles -> no state change; decEn=0 with pop=1 -> no change.
REQ-040 Assert rst mid-burst between clock edges -> all outputs 0 without a clock edge; resume pushing after release -> first push lands at ptr=1 with cnt=1.
